div_sequencer: RTL and testbench

Multi-cycle sequencer for the CPU's integer divide path. It accepts a DIV/DIVU request from the Control Unit and runs a 32-step restoring shift-subtract over the operands. It applies sign correction, then writes the quotient to LO and the remainder to HI. It also provides a busy stall to the pipeline, a divide-by-zero trap pulse and a flush abort.

---
 rtl/div_sequencer_pkg.sv | 25 ++
 rtl/div_sequencer_if.sv | 32 +++
 rtl/div_sequencer_step.sv | 32 +++
 rtl/div_sequencer.sv | 149 ++++++++++++++
 tb/tb_div_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the integer divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Iteration count for the default 32-bit datapath
    localparam int DIV_ITERS    = 32;

    // Bit of the Control Unit sign field that selects signed (DIV) mode
    localparam int SIGN_SEL_BIT = 1;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_sequencer_if
//  Description : Request/result bundle between the Control Unit (master) and
//                the divide sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        sign;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              flush;
    logic [DATA_W-1:0] hi_res;
    logic [DATA_W-1:0] lo_quo;
    logic              busy;
    logic              done;
    logic              dz_trap;

    modport master (
        output start, sign, dividend, divisor, flush,
        input  hi_res, lo_quo, busy, done, dz_trap
    );

    modport slave (
        input  start, sign, dividend, divisor, flush,
        output hi_res, lo_quo, busy, done, dz_trap
    );
endinterface
`default_nettype wire

// File: rtl/div_sequencer_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring shift-subtract step.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0] rem,
    input  wire logic [DATA_W-1:0] quo,
    input  wire logic [DATA_W-1:0] dvs,
    output logic      [DATA_W-1:0] rem_nx,
    output logic      [DATA_W-1:0] quo_nx
);
    logic [DATA_W:0]   w_shift;
    logic [DATA_W+1:0] w_diff;
    logic              w_fits;

    // Shift {rem, quo} left by one; the partial remainder can briefly need
    // DATA_W+1 bits, and one extra guard bit on the subtract exposes the
    // borrow so the trial result's sign is unambiguous.
    always_comb begin
        w_shift = {rem, quo[DATA_W-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, dvs};
        w_fits  = ~w_diff[DATA_W+1];
        rem_nx  = w_fits ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
        quo_nx  = {quo[DATA_W-2:0], w_fits};
    end

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : div_sequencer
//  Description : Multi-cycle restoring divider for DIV/DIVU. Quotient goes to
//                LO, remainder to HI; provides busy stall, divide-by-zero
//                trap pulse and flush abort.
//                Optional feature macro: DIV_EARLY_OUT_EN (skip iterations
//                when |divisor| > |dividend|).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer
    import div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    div_sequencer_if.slave    bus
);
    localparam int c_CNT_W = $clog2(DATA_W + 1);

    div_state_t           r_state;
    div_state_t           w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [DATA_W-1:0]    r_rem;
    logic [DATA_W-1:0]    r_quo;
    logic [DATA_W-1:0]    r_dvs;
    logic [DATA_W-1:0]    r_hi;
    logic [DATA_W-1:0]    r_lo;
    logic                 r_signed;
    logic                 r_q_neg;
    logic                 r_r_neg;
    logic                 r_dz;

    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [DATA_W-1:0]    w_mag_a;
    logic [DATA_W-1:0]    w_mag_b;
    logic [DATA_W-1:0]    w_rem_nx;
    logic [DATA_W-1:0]    w_quo_nx;
    logic                 w_early;

    // Operand magnitudes from the latched request; only negative in signed mode
    assign w_neg_a = r_signed & r_a[DATA_W-1];
    assign w_neg_b = r_signed & r_b[DATA_W-1];
    assign w_mag_a = w_neg_a ? (~r_a + 1'b1) : r_a;
    assign w_mag_b = w_neg_b ? (~r_b + 1'b1) : r_b;

`ifdef DIV_EARLY_OUT_EN
    // Quotient is trivially zero when the divisor outweighs the dividend
    assign w_early = (w_mag_b > w_mag_a);
`else
    assign w_early = 1'b0;
`endif

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem    (r_rem),
        .quo    (r_quo),
        .dvs    (r_dvs),
        .rem_nx (w_rem_nx),
        .quo_nx (w_quo_nx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.start) w_next = (bus.divisor == '0) ? DONE : PREP;
            PREP: w_next = w_early ? DONE : ITER;
            ITER: if (r_cnt == c_CNT_W'(DATA_W - 1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.flush) w_next = IDLE;
    end

    // Datapath: operand capture, iteration, sign fix-up and HI/LO write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_signed <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_a      <= bus.dividend;
                        r_b      <= bus.divisor;
                        r_signed <= bus.sign[SIGN_SEL_BIT];
                        r_dz     <= (bus.divisor == '0);
                    end
                end
                PREP: begin
                    r_rem   <= '0;
                    r_quo   <= w_mag_a;
                    r_dvs   <= w_mag_b;
                    r_q_neg <= w_neg_a ^ w_neg_b;
                    r_r_neg <= w_neg_a;
                    r_cnt   <= '0;
`ifdef DIV_EARLY_OUT_EN
                    if (w_next == DONE) begin
                        r_lo <= '0;
                        r_hi <= r_a;
                    end
`endif
                end
                ITER: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    // Gated on the DONE transition so a flush here leaves HI/LO intact
                    if (w_next == DONE) begin
                        r_lo <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
                        r_hi <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state == PREP) || (r_state == ITER) || (r_state == FIX);
    assign bus.done    = (r_state == DONE);
    assign bus.dz_trap = (r_state == DONE) && r_dz;
    assign bus.hi_res  = r_hi;
    assign bus.lo_quo  = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_sequencer
//  Description : Directed scoreboard bench for div_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        logic [7:0]  cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] m_lo;
    logic [31:0] m_hi;
    exp_t sb[$];

    div_sequencer_if #(.DATA_W(32)) bus ();

    div_sequencer #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        exp_t e;
        logic [31:0] ma, mb;
        e.dz = 1'b0;
        if (b == 32'd0) begin
            e.lo = m_lo; e.hi = m_hi; e.dz = 1'b1; e.cyc = 8'd1;
            return e;
        end
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = a; e.hi = 32'd0;
            end else begin
                e.lo = $signed(a) / $signed(b);
                e.hi = $signed(a) % $signed(b);
            end
            ma = a[31] ? -a : a;
            mb = b[31] ? -b : b;
        end else begin
            e.lo = a / b; e.hi = a % b;
            ma = a; mb = b;
        end
        e.cyc = 8'd35;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) e.cyc = 8'd2;
`endif
        return e;
    endfunction

    // Issue one request from a sample point; inj>0 fires a stray start in that cycle
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int inj);
        exp_t e, x;
        int   busy_bad;
        bit   seen;
        logic exp_busy;
        e = model(a, b, sgn);
        sb.push_back(e);
        bus.dividend = a; bus.divisor = b; bus.sign = {sgn, 1'b0}; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_bad = 0; seen = 0;
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            exp_busy = !e.dz && (cyc < int'(e.cyc));
            if (bus.busy !== exp_busy) busy_bad++;
            if (bus.done === 1'b1) begin
                seen = 1;
                x = sb.pop_front();
                chk({tag, "_cyc"}, 64'(cyc), 64'(x.cyc));
                chk({tag, "_lo"},  64'(bus.lo_quo), 64'(x.lo));
                chk({tag, "_hi"},  64'(bus.hi_res), 64'(x.hi));
                chk({tag, "_dz"},  64'(bus.dz_trap), 64'(x.dz));
                if (!x.dz) begin m_lo = x.lo; m_hi = x.hi; end
            end
            if (cyc == inj) begin
                bus.dividend = 32'd50; bus.divisor = 32'd5; bus.sign = 2'b00; bus.start = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        int dones;
        logic [31:0] ra, rb;
        n_cmp = 0; n_err = 0; m_lo = '0; m_hi = '0;
        bus.start = 1'b0; bus.sign = 2'b00; bus.dividend = '0; bus.divisor = '0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi",   64'(bus.hi_res),  64'd0);
        chk("rst_lo",   64'(bus.lo_quo),  64'd0);
        chk("rst_busy", 64'(bus.busy),    64'd0);
        chk("rst_done", 64'(bus.done),    64'd0);
        chk("rst_dz",   64'(bus.dz_trap), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("u100_7",  32'd100,        32'd7,          1'b0, 0);
        run_op("dz",      32'd55,         32'd0,          1'b1, 0);
        run_op("sm7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 0);
        run_op("s7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 0);
        run_op("ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0);
        run_op("udiv_lg", 32'hFFFF_FFF9,  32'd2,          1'b0, 0);
        run_op("ign_st",  32'd100,        32'd7,          1'b0, 5);

        // Flush in cycle 10 of a running operation
        bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.sign = 2'b00; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        chk("flush_nodone", 64'(dones), 64'd0);
        chk("flush_lo", 64'(bus.lo_quo), 64'(m_lo));
        chk("flush_hi", 64'(bus.hi_res), 64'(m_hi));

        // Start and flush together in IDLE: start dropped
        bus.dividend = 32'd9; bus.divisor = 32'd0; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("stfl_done", 64'({bus.done, bus.busy}), 64'd0);
        @(posedge clk); #1;

        run_op("u3_10",  32'd3,          32'd10, 1'b0, 0);
        run_op("sm3_10", 32'hFFFF_FFFD,  32'd10, 1'b1, 0);

        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd13;
            run_op("rand", ra, rb, k[0], 0);
        end

        // Asynchronous reset in the middle of an operation
        bus.dividend = 32'd77; bus.divisor = 32'd5; bus.sign = 2'b00; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy),   64'd0);
        chk("arst_lo",   64'(bus.lo_quo), 64'd0);
        chk("arst_hi",   64'(bus.hi_res), 64'd0);
        m_lo = '0; m_hi = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 32'd100, 32'd7, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
